// File: rtl/klein_pkg.sv
// rtl/klein_pkg.sv - shared KLEIN-80 constants, key type and byte substitution
package klein_pkg;

  localparam int KLEIN_KEY_W    = 80;
  localparam int KLEIN80_ROUNDS = 16;

  // Nibble 0 of the S-box sits in the most significant nibble.
  localparam logic [63:0] KLEIN_SBOX = 64'h74A9_1FB0_C326_8ED5;

  typedef logic [KLEIN_KEY_W-1:0] klein_key_t;

  typedef enum logic {
    DKS_IDLE,
    DKS_EMIT
  } dks_state_e;

  function automatic logic [3:0] klein_sbox4(input logic [3:0] n);
    logic [63:0] t;
    t = KLEIN_SBOX << {n, 2'b00};
    return t[63:60];
  endfunction

  function automatic logic [7:0] klein_sub_byte(input logic [7:0] b);
    return {klein_sbox4(b[7:4]), klein_sbox4(b[3:0])};
  endfunction

endpackage

// File: rtl/klein_inv_key_round.sv
// rtl/klein_inv_key_round.sv - one combinational inverse KLEIN-80 key schedule round
module klein_inv_key_round
  import klein_pkg::*;
(
  input  klein_key_t  key_i,
  input  logic [7:0]  cnt_i,
  output klein_key_t  key_o
);

  logic [39:0] a_half;
  logic [39:0] b_half;
  logic [39:0] ar;
  logic [39:0] br;

  // Undo the forward steps in reverse: S-box, counter XOR, swap-XOR, rotate.
  always_comb begin
    a_half         = key_i[79:40];
    b_half         = key_i[39:0];
    b_half[31:24]  = klein_sub_byte(key_i[31:24]);
    b_half[23:16]  = klein_sub_byte(key_i[23:16]);
    a_half[23:16]  = key_i[63:56] ^ cnt_i;
    br             = a_half;
    ar             = b_half ^ a_half;
    key_o          = {ar[7:0], ar[39:8], br[7:0], br[39:8]};
  end

endmodule

// File: rtl/klein_dec_key_sched.sv
// rtl/klein_dec_key_sched.sv - iterative KLEIN-80 inverse key schedule, sk16 down to sk0
// Optional abort input enabled by defining KLEIN_DKS_ABORT_EN.
module klein_dec_key_sched
  import klein_pkg::*;
#(
  parameter int ROUNDS = KLEIN80_ROUNDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  klein_key_t  final_key,
  input  logic        rk_ready,
`ifdef KLEIN_DKS_ABORT_EN
  input  logic        abort,
`endif
  output klein_key_t  rk,
  output logic [4:0]  rk_idx,
  output logic        rk_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [4:0] IDX_INIT = 5'(ROUNDS);

  dks_state_e state_q, state_d;
  klein_key_t rk_q, rk_d, rk_prev;
  logic [4:0] idx_q, idx_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       abort_w;

`ifdef KLEIN_DKS_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  klein_inv_key_round u_inv_round (
    .key_i (rk_q),
    .cnt_i ({3'b000, idx_q}),
    .key_o (rk_prev)
  );

  always_comb begin
    state_d = state_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      DKS_IDLE: begin
        if (start) begin
          rk_d    = final_key;
          idx_d   = IDX_INIT;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = DKS_EMIT;
        end
      end
      DKS_EMIT: begin
        // Abort wins over a handshake in the same cycle.
        if (abort_w) begin
          rk_d    = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = DKS_IDLE;
        end else if (rk_ready) begin
          if (idx_q != 5'd0) begin
            rk_d  = rk_prev;
            idx_d = idx_q - 5'd1;
          end else begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DKS_IDLE;
          end
        end
      end
      default: state_d = DKS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DKS_IDLE;
      rk_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rk       = rk_q;
  assign rk_idx   = idx_q;
  assign rk_valid = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_klein_dec_key_sched.sv
// tb/tb_klein_dec_key_sched.sv - self-checking bench for klein_dec_key_sched
module tb_klein_dec_key_sched;

  typedef struct {
    logic [79:0] key;
    int          mode;
    logic [79:0] exp_last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rk_ready = 1'b0;
  logic [79:0] final_key = '0;
  logic [79:0] rk;
  logic [4:0]  rk_idx;
  logic        rk_valid;
  logic        busy;
  logic        done;
`ifdef KLEIN_DKS_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  logic [79:0] sched [17];
  logic [3:0]  sbox_t [16] = '{4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
                               4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5};

  klein_dec_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .final_key (final_key),
    .rk_ready  (rk_ready),
`ifdef KLEIN_DKS_ABORT_EN
    .abort     (abort),
`endif
    .rk        (rk),
    .rk_idx    (rk_idx),
    .rk_valid  (rk_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] sb(input logic [7:0] x);
    return {sbox_t[x[7:4]], sbox_t[x[3:0]]};
  endfunction

  // Forward KLEIN-80 key_gen step on byte arrays.
  function automatic logic [79:0] kg(input logic [79:0] k, input logic [7:0] i);
    logic [7:0] a [5];
    logic [7:0] b [5];
    logic [7:0] na [5];
    logic [7:0] nb [5];
    logic [79:0] r;
    for (int j = 0; j < 5; j++) begin
      a[j] = k[79-8*j -: 8];
      b[j] = k[39-8*j -: 8];
    end
    for (int j = 0; j < 5; j++) begin
      na[j] = b[(j+1)%5];
      nb[j] = a[(j+1)%5] ^ b[(j+1)%5];
    end
    na[2] = na[2] ^ i;
    nb[1] = sb(nb[1]);
    nb[2] = sb(nb[2]);
    r = '0;
    for (int j = 0; j < 5; j++) begin
      r[79-8*j -: 8] = na[j];
      r[39-8*j -: 8] = nb[j];
    end
    return r;
  endfunction

  task automatic build(input logic [79:0] k0);
    sched[0] = k0;
    for (int i = 1; i <= 16; i++) sched[i] = kg(sched[i-1], 8'(i));
  endtask

  task automatic chk_k(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input logic [79:0] k);
    final_key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Walks an active sequence from rk_idx 16; stop_idx >= 0 leaves it mid-run.
  task automatic run_seq(input int mode, input int ign_idx, input int stop_idx, output int cycles);
    int idx;
    int cyc;
    bit rdy;
    idx = 16;
    cyc = 0;
    while (idx >= 0 && cyc < 300) begin
      chk_i("rk_valid", int'(rk_valid), 1);
      chk_i("rk_idx", int'(rk_idx), idx);
      chk_k("rk", rk, sched[idx]);
      chk_i("busy", int'(busy), 1);
      if (idx == stop_idx) break;
      if (idx == ign_idx) begin
        start = 1'b1;
        final_key = ~sched[16];
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      rk_ready = rdy;
      tick();
      start = 1'b0;
      rk_ready = 1'b0;
      if (rdy) idx--;
      cyc++;
    end
    cycles = cyc;
    if (cyc >= 300) chk_i("timeout", 1, 0);
    if (stop_idx < 0 && idx < 0) begin
      chk_i("done_pulse", int'(done), 1);
      chk_i("busy_end", int'(busy), 0);
      chk_i("valid_end", int'(rk_valid), 0);
    end
  endtask

  initial begin
    vec_t vecs [5];
    int   cyc;
    logic [79:0] x;

    vecs[0] = '{80'h0123456789ABCDEF0123, 0, 80'h0123456789ABCDEF0123};
    vecs[1] = '{80'hFFFFFFFFFFFFFFFFFFFF, 1, 80'hFFFFFFFFFFFFFFFFFFFF};
    vecs[2] = '{80'h0, 2, 80'h0};
    x = {$urandom(), $urandom(), 16'($urandom())};
    vecs[3] = '{x, 2, x};
    x = {$urandom(), $urandom(), 16'($urandom())};
    vecs[4] = '{x, 1, x};

    tick();
    tick();
    chk_k("reset_rk", rk, 80'h0);
    chk_i("reset_idx", int'(rk_idx), 0);
    chk_i("reset_valid", int'(rk_valid), 0);
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_done", int'(done), 0);
    rst_n = 1'b1;
    tick();

    // Single inverse step from key_gen(X, 16)
    x = 80'hFFFFFFFFFFFFFFFFFFFF;
    start_seq(kg(x, 8'h10));
    chk_i("single_idx16", int'(rk_idx), 16);
    rk_ready = 1'b1;
    tick();
    chk_i("single_idx15", int'(rk_idx), 15);
    chk_k("single_rk15", rk, x);
    for (int i = 0; i < 30; i++) begin
      if (done) break;
      tick();
    end
    rk_ready = 1'b0;
    chk_i("single_done", int'(done), 1);
    tick();

    for (int v = 0; v < 5; v++) begin
      build(vecs[v].key);
      start_seq(sched[16]);
      run_seq(vecs[v].mode, -1, -1, cyc);
      chk_k("final_rk", rk, vecs[v].exp_last);
      if (vecs[v].mode == 0) chk_i("full_cycles", cyc, 17);
      tick();
      chk_i("done_one_cycle", int'(done), 0);
    end

    // start mid-sequence is ignored, start coincident with done is accepted
    build(80'hA5A5_0F0F_1234_5678_9ABC);
    start_seq(sched[16]);
    run_seq(0, 9, -1, cyc);
    build(80'h1357_9BDF_2468_ACE0_FEDC);
    final_key = sched[16];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_i("restart_idx", int'(rk_idx), 16);
    chk_k("restart_rk", rk, sched[16]);
    chk_i("restart_valid", int'(rk_valid), 1);

    // asynchronous reset at rk_idx 5
    run_seq(0, -1, 5, cyc);
    rst_n = 1'b0;
    #1;
    chk_k("arst_rk", rk, 80'h0);
    chk_i("arst_idx", int'(rk_idx), 0);
    chk_i("arst_valid", int'(rk_valid), 0);
    chk_i("arst_busy", int'(busy), 0);
    chk_i("arst_done", int'(done), 0);
    #2;
    rst_n = 1'b1;
    rk_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_i("idle_valid", int'(rk_valid), 0);
      chk_i("idle_busy", int'(busy), 0);
    end
    rk_ready = 1'b0;

`ifdef KLEIN_DKS_ABORT_EN
    build(80'hDEAD_BEEF_CAFE_F00D_0123);
    start_seq(sched[16]);
    run_seq(0, -1, 3, cyc);
    abort = 1'b1;
    rk_ready = 1'b1;
    tick();
    abort = 1'b0;
    rk_ready = 1'b0;
    chk_i("abort_valid", int'(rk_valid), 0);
    chk_i("abort_busy", int'(busy), 0);
    chk_i("abort_done", int'(done), 0);
    chk_k("abort_rk", rk, 80'h0);
    tick();
    chk_i("abort_stays_idle", int'(rk_valid), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
